// File: rtl/phase_noise_source.sv
// Phase-modulated tone source: accumulator + offset + LFSR noise folded through a quarter-wave sine ROM.
// Latency: tick at edge E -> valid_o after edge E+3; no stalls, config accepted by valid/ready handshake.
module phase_noise_source #(
  parameter int          LUT_ADDR_W = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               tick_i,
  input  logic [31:0]        fcw_i,
  input  logic signed [15:0] pm_i,
  input  logic               noise_en_i,
  input  logic [3:0]         noise_shift_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  output logic signed [15:0] signal_o,
  output logic [15:0]        phase_o,
  output logic               valid_o
);

  localparam int LUT_N = 2 ** LUT_ADDR_W;

  typedef struct packed {
    logic [31:0] fcw;
    logic [15:0] pm;
    logic        noise_en;
    logic [3:0]  noise_shift;
  } cfg_t;

  function automatic logic signed [15:0] lut_entry(input int idx);
    real x, term, s;
    x    = 1.5707963267948966 * (real'(idx) + 0.5) / real'(LUT_N);
    term = x;
    s    = x;
    for (int n = 1; n < 10; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    return 16'($rtoi(32767.0 * s + 0.5));
  endfunction

  logic signed [15:0] lut [LUT_N];

  for (genvar i = 0; i < LUT_N; i++) begin : g_lut
    localparam logic signed [15:0] ENTRY = lut_entry(i);
    assign lut[i] = ENTRY;
  end

  cfg_t cfg_in, cfg_shadow, cfg_active, cfg_eff;
  logic pending, xfer;

  assign cfg_in      = '{fcw: fcw_i, pm: pm_i, noise_en: noise_en_i, noise_shift: noise_shift_i};
  assign cfg_ready_o = ~pending;
  assign xfer        = cfg_valid_i & ~pending;

  // A committing tick must see the newest config, whether held in the shadow or offered this cycle.
  always_comb begin
    cfg_eff = cfg_active;
    if (pending)   cfg_eff = cfg_shadow;
    else if (xfer) cfg_eff = cfg_in;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_shadow <= '0;
      cfg_active <= '0;
      pending    <= 1'b0;
    end else if (tick_i) begin
      cfg_active <= cfg_eff;
      pending    <= 1'b0;
    end else if (xfer) begin
      cfg_shadow <= cfg_in;
      pending    <= 1'b1;
    end
  end

  logic [31:0]        acc;
  logic [15:0]        lfsr, lfsr_step;
  logic signed [15:0] noise;
  logic               tick_d, s1_vld, s2_vld;
  logic [15:0]        s1_ph, s2_ph;
  logic [LUT_ADDR_W-1:0] s2_k;
  logic               s2_neg;

  // Galois form of x^16+x^14+x^13+x^11+1
  assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign noise     = cfg_active.noise_en ? ($signed(lfsr) >>> cfg_active.noise_shift) : 16'sd0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc      <= '0;
      lfsr     <= LFSR_SEED;
      tick_d   <= 1'b0;
      s1_vld   <= 1'b0;
      s2_vld   <= 1'b0;
      valid_o  <= 1'b0;
      s1_ph    <= '0;
      s2_ph    <= '0;
      s2_k     <= '0;
      s2_neg   <= 1'b0;
      signal_o <= '0;
      phase_o  <= '0;
    end else begin
      tick_d  <= tick_i;
      s1_vld  <= tick_d;
      s2_vld  <= s1_vld;
      valid_o <= s2_vld;
      if (tick_i) begin
        acc  <= acc + cfg_eff.fcw;
        lfsr <= lfsr_step;
      end
      if (tick_d) s1_ph <= acc[31:16] + cfg_active.pm + noise;
      if (s1_vld) begin
        s2_ph  <= s1_ph;
        s2_neg <= s1_ph[15];
        s2_k   <= s1_ph[14] ? ~s1_ph[13 -: LUT_ADDR_W] : s1_ph[13 -: LUT_ADDR_W];
      end
      if (s2_vld) begin
        signal_o <= s2_neg ? -lut[s2_k] : lut[s2_k];
        phase_o  <= s2_ph;
      end
    end
  end

endmodule

// File: tb/tb_phase_noise_source.sv
// Directed bench for phase_noise_source: reset, quadrant walk, handshake, noise, reset mid-pipeline.
module tb_phase_noise_source;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               tick_i;
  logic [31:0]        fcw_i;
  logic signed [15:0] pm_i;
  logic               noise_en_i;
  logic [3:0]         noise_shift_i;
  logic               cfg_valid_i;
  logic               cfg_ready_o;
  logic signed [15:0] signal_o;
  logic [15:0]        phase_o;
  logic               valid_o;

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0]        lfsr_m;
  logic signed [15:0] nz, dev;

  phase_noise_source #(.LUT_ADDR_W(8), .LFSR_SEED(16'hACE1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tick_i(tick_i), .fcw_i(fcw_i), .pm_i(pm_i),
    .noise_en_i(noise_en_i), .noise_shift_i(noise_shift_i), .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o), .signal_o(signal_o), .phase_o(phase_o), .valid_o(valid_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check16({tag, "_sig"}, signal_o, 16'h0000);
    check16({tag, "_ph"}, phase_o, 16'h0000);
    checkb({tag, "_vld"}, valid_o, 1'b0);
    checkb({tag, "_rdy"}, cfg_ready_o, 1'b1);
  endtask

  task automatic offer(input logic [31:0] f, input logic [15:0] p, input logic en, input logic [3:0] sh);
    fcw_i = f; pm_i = p; noise_en_i = en; noise_shift_i = sh;
    cfg_valid_i = 1'b1;
    step();
    cfg_valid_i = 1'b0;
  endtask

  // One tick; checks ready after the tick edge and that valid_o appears exactly 3 cycles later.
  task automatic do_tick(input string tag, input logic [15:0] eph, input logic signed [15:0] esig,
                         input bit chk_sig);
    tick_i = 1'b1;
    step();
    tick_i      = 1'b0;
    cfg_valid_i = 1'b0;
    checkb({tag, "_rdy"}, cfg_ready_o, 1'b1);
    step();
    checkb({tag, "_vld_e1"}, valid_o, 1'b0);
    step();
    checkb({tag, "_vld_e2"}, valid_o, 1'b0);
    step();
    checkb({tag, "_vld_e3"}, valid_o, 1'b1);
    check16({tag, "_ph"}, phase_o, eph);
    if (chk_sig) check16({tag, "_sig"}, signal_o, esig);
    step();
    checkb({tag, "_vld_e4"}, valid_o, 1'b0);
    check16({tag, "_ph_hold"}, phase_o, eph);
  endtask

  initial begin
    rst_i = 1'b1; tick_i = 1'b0; cfg_valid_i = 1'b0;
    fcw_i = '0; pm_i = '0; noise_en_i = 1'b0; noise_shift_i = '0;
    lfsr_m = 16'hACE1;
    #1;
    for (int c = 0; c < 3; c++) begin
      check_idle("rst");
      step();
    end
    rst_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check_idle("post_rst");
    end

    // Handshake: first offer held, second offer ignored while pending.
    offer(32'h4000_0000, 16'h0000, 1'b0, 4'd0);
    checkb("hs_rdy_low0", cfg_ready_o, 1'b0);
    step();
    checkb("hs_rdy_low1", cfg_ready_o, 1'b0);
    offer(32'h1234_5678, 16'h0555, 1'b1, 4'd3);
    checkb("hs_rdy_low2", cfg_ready_o, 1'b0);

    // Quadrant walk, ticks 10 cycles apart.
    do_tick("qw0", 16'h4000, 16'sd32767, 1'b1);
    repeat (5) step();
    do_tick("qw1", 16'h8000, -16'sd101, 1'b1);
    repeat (5) step();
    do_tick("qw2", 16'hC000, -16'sd32767, 1'b1);
    repeat (5) step();
    do_tick("qw3", 16'h0000, 16'sd101, 1'b1);
    repeat (5) step();

    // Offer and tick in the same cycle: acc wrapped to 0, so phase = 0x1000, lut[64] = 12632.
    fcw_i = 32'h1000_0000; pm_i = '0; noise_en_i = 1'b0; noise_shift_i = '0;
    cfg_valid_i = 1'b1;
    do_tick("sim", 16'h1000, 16'sd12632, 1'b1);
    checkb("sim_rdy_after", cfg_ready_o, 1'b1);

    // Noise, shift 4, from a fresh LFSR and accumulator.
    rst_i = 1'b1;
    lfsr_m = 16'hACE1;
    step();
    rst_i = 1'b0;
    step();
    offer(32'h0000_0000, 16'h2000, 1'b1, 4'd4);
    for (int i = 0; i < 1000; i++) begin
      lfsr_m = lfsr_next(lfsr_m);
      nz = $signed(lfsr_m) >>> 4;
      do_tick("nz4", 16'h2000 + nz, 16'sd0, 1'b0);
      dev = phase_o - 16'h2000;
      checkb("nz4_mag", (dev <= 16'sd2048) && (dev >= -16'sd2048), 1'b1);
    end

    // Noise, shift 15, committed by a same-cycle offer on the first tick.
    for (int i = 0; i < 1000; i++) begin
      if (i == 0) begin
        fcw_i = '0; pm_i = 16'h2000; noise_en_i = 1'b1; noise_shift_i = 4'd15;
        cfg_valid_i = 1'b1;
      end
      lfsr_m = lfsr_next(lfsr_m);
      nz = $signed(lfsr_m) >>> 15;
      do_tick("nz15", 16'h2000 + nz, 16'sd0, 1'b0);
      dev = phase_o - 16'h2000;
      checkb("nz15_range", (dev == -16'sd1) || (dev == 16'sd0), 1'b1);
    end

    // Reset one cycle after back-to-back ticks: in-flight samples must vanish.
    tick_i = 1'b1;
    step();
    step();
    tick_i = 1'b0;
    rst_i  = 1'b1;
    lfsr_m = 16'hACE1;
    #1;
    checkb("rm_vld_rst", valid_o, 1'b0);
    step();
    rst_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checkb("rm_vld_flush", valid_o, 1'b0);
      step();
    end
    check_idle("rm_idle");
    offer(32'h4000_0000, 16'h0000, 1'b0, 4'd0);
    do_tick("rm0", 16'h4000, 16'sd32767, 1'b1);
    do_tick("rm1", 16'h8000, -16'sd101, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
